reg_file_ras: RTL
=================

# reg_file_ras

Parametrised CPU register file with an integrated hardware return-address stack (RAS) that is separate from the general registers. It sits in the ID stage: it serves two registered operand reads and one WB write per cycle, plus call/return push/pop of PC-derived return addresses. Unlike the previous generation, it has configurable width, register count and stack depth, WB-to-ID forwarding, explicit full/empty status, and sticky overflow/underflow error flags. A mode parameter selects whether a push onto a full stack is dropped or overwrites the oldest entry.

## Interface
- DATA_W, 32, register width
- NUM_REGS, 8, general registers; index width RA_W = clog2(NUM_REGS)
- PC_W, 8, PC width; pushed value = PC + 1, zero-extended to PC_W
- STACK_DEPTH, 8, RAS entries, power of two ≥ 2
- OVF_WRAP, 0, 0 = drop push when full; 1 = overwrite oldest entry
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- WB_regwrite  in  1  write wd to register ws
- ws  in  RA_W  write index
- wd  in  DATA_W  write data
- rs1, rs2  in  RA_W  read indices
- ID_push  in  1  push stack_pc + 1
- ID_pop  in  1  pop top of stack
- stack_pc  in  PC_W  PC of the call instruction
- ID_rd1, ID_rd2  out  DATA_W  registered read data
- pop_data  out  PC_W  registered popped return address
- pop_valid  out  1  pop_data valid this cycle
- ras_full, ras_empty  out  1  stack status, registered
- ras_ovf, ras_udf  out  1  sticky error flags, cleared only by reset

## Operation
- Register array and RAS are separate storage. WB write and push/pop are independent and may all occur in the same cycle.
- Reads: on each edge, ID_rdN <= (WB_regwrite && ws == rsN) ? wd : regs[rsN], giving write-through forwarding.
- Write: regs[ws] <= wd when WB_regwrite.
- RAS state: top pointer tp (clog2 depth bits, wraps modulo STACK_DEPTH) and count cnt (0..STACK_DEPTH).
- Push only:
  - not full: mem[tp+1] <= stack_pc+1; tp++; cnt++.
  - full, OVF_WRAP=0: push dropped; ras_ovf set.
  - full, OVF_WRAP=1: same write and tp++; cnt stays at STACK_DEPTH (oldest entry lost); ras_ovf set.
- Pop only:
  - not empty: pop_data <= mem[tp]; tp--; cnt--; pop_valid=1.
  - empty: pop_data <= 0; pop_valid=0; ras_udf set.
- Push and pop together:
  - not empty: pop_data <= old mem[tp]; mem[tp] <= stack_pc+1; tp and cnt unchanged; pop_valid=1.
  - empty: pop_data <= stack_pc+1 (bypass); state unchanged; pop_valid=1; no error.
- PC+1 wraps within PC_W (8'hFF -> 8'h00).
- ras_full = (cnt == STACK_DEPTH); ras_empty = (cnt == 0).

## Timing
- All outputs are registered. Read latency is 1 cycle; pop latency is 1 cycle; pop_valid is a 1-cycle pulse aligned with pop_data.
- Status flags reflect post-edge state (the push that fills the stack shows ras_full on the next cycle).
- Reset (asynchronous, any time, including mid-push/pop) takes effect immediately:
  - all registers 0, RAS memory 0, tp = 0, cnt = 0.
  - ID_rd1/2 = 0, pop_data = 0, pop_valid = 0, ras_empty = 1, ras_full = 0, ras_ovf = ras_udf = 0.
- First edge after reset_n rises operates normally; no warm-up cycles.

## Structure
- Package rf_pkg: RA_W/SP_W clog2 helpers, default parameter constants, ras_op enum {NONE, PUSH, POP, SWAP}.
- Sub-module ras_stack holds the RAS pointer/count, memory, flags and pop output. The top level holds the register array, forwarding and read registers.
- No initial blocks or debug tasks in synthesizable RTL.

## Test plan
- Reset then write regs 0..3 = 10, 20, 30, 40; read rs1=2, rs2=3 -> next cycle ID_rd1=30, ID_rd2=40.
- WB_regwrite ws=5 wd=0xAA with rs1=5 in the same cycle -> ID_rd1=0xAA next cycle (forwarded).
- Push stack_pc 0x10, 0x20, 0x30, then pop ×3 -> pop_data 0x31, 0x21, 0x11 with pop_valid each cycle; ras_empty=1 at the end; one more pop -> ras_udf=1, pop_valid=0.
- Depth 8, OVF_WRAP=0: 9 pushes of 0..8 -> ras_ovf=1, ras_full=1; 8 pops return 8..1.
- Same stimulus with OVF_WRAP=1: pops return 9..2.
- Simultaneous push 0x40 and pop with top=0x21 -> pop_data=0x21 and cnt unchanged; the next pop returns 0x41. Assert reset_n low mid-sequence -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the register file / return-address stack slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_REGS    = 8;
    localparam int DEF_PC_W        = 8;
    localparam int DEF_STACK_DEPTH = 8;
    localparam bit DEF_OVF_WRAP    = 1'b0;

    // Register index width; a single-register file still needs one index bit.
    function automatic int ra_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // Stack pointer width for a power-of-two depth.
    function automatic int sp_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Encoding matches {push, pop} so the request bits cast directly.
    typedef enum logic [1:0] {
        RAS_NONE = 2'b00,
        RAS_POP  = 2'b01,
        RAS_PUSH = 2'b10,
        RAS_SWAP = 2'b11
    } ras_op_e;

endpackage

// File: rtl/reg_file_ras_if.sv
// ID-stage bus for reg_file_ras: WB write, two operand reads, call/return stack requests and status.
// Latency: n/a (wires only); all DUT outputs on this bus are registered.
// Backpressure: none; every request is accepted on the edge it is presented.
// Ports: master drives WB_regwrite/ws/wd/rs1/rs2/ID_push/ID_pop/stack_pc; slave drives
//        ID_rd1/ID_rd2/pop_data/pop_valid/ras_full/ras_empty/ras_ovf/ras_udf.
interface reg_file_ras_if
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int PC_W     = DEF_PC_W
);
    localparam int RA_W = ra_w(NUM_REGS);

    logic              WB_regwrite;
    logic [RA_W-1:0]   ws;
    logic [DATA_W-1:0] wd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic              ID_push;
    logic              ID_pop;
    logic [PC_W-1:0]   stack_pc;
    logic [DATA_W-1:0] ID_rd1;
    logic [DATA_W-1:0] ID_rd2;
    logic [PC_W-1:0]   pop_data;
    logic              pop_valid;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_ovf;
    logic              ras_udf;

    modport master (
        output WB_regwrite, ws, wd, rs1, rs2, ID_push, ID_pop, stack_pc,
        input  ID_rd1, ID_rd2, pop_data, pop_valid, ras_full, ras_empty, ras_ovf, ras_udf
    );

    modport slave (
        input  WB_regwrite, ws, wd, rs1, rs2, ID_push, ID_pop, stack_pc,
        output ID_rd1, ID_rd2, pop_data, pop_valid, ras_full, ras_empty, ras_ovf, ras_udf
    );

endinterface

// File: rtl/reg_file_ras_stack.sv
// Hardware return-address stack: push PC+1 on call, pop on return, swap when both arrive together.
// Latency: 1 cycle from request to pop_data/pop_valid and to updated full/empty/ovf/udf.
// Backpressure: none; full pushes are dropped or overwrite the oldest entry, empty pops flag underflow.
// Ports: clk, reset_n; i_push/i_pop/i_pc requests; o_pop_data/o_pop_valid result; status flags.
module ras_stack
    import rf_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter bit OVF_WRAP    = DEF_OVF_WRAP
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_pc,
    output logic [PC_W-1:0] o_pop_data,
    output logic            o_pop_valid,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_ovf,
    output logic            o_udf
);
    localparam int                SP_W     = sp_w(STACK_DEPTH);
    localparam int                CNT_W    = SP_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [PC_W-1:0]  r_mem [STACK_DEPTH];
    logic [SP_W-1:0]  r_tp;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_pop_dat;
    logic             r_pop_vld, r_full, r_empty, r_ovf, r_udf;

    ras_op_e          w_op;
    logic [PC_W-1:0]  w_ret_pc;
    logic             w_full, w_empty;
    logic [SP_W-1:0]  w_tp_nxt, w_wr_idx;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PC_W-1:0]  w_pop_dat_nxt;
    logic             w_wr_en, w_pop_vld_nxt, w_set_ovf, w_set_udf;

    assign w_op     = ras_op_e'({i_push, i_pop});
    assign w_ret_pc = i_pc + 1'b1;
    assign w_full   = (r_cnt == FULL_CNT);
    assign w_empty  = (r_cnt == '0);

    always_comb begin
        w_tp_nxt      = r_tp;
        w_cnt_nxt     = r_cnt;
        w_wr_en       = 1'b0;
        w_wr_idx      = r_tp + 1'b1;
        w_pop_dat_nxt = r_pop_dat;
        w_pop_vld_nxt = 1'b0;
        w_set_ovf     = 1'b0;
        w_set_udf     = 1'b0;
        case (w_op)
            RAS_NONE: begin
            end
            RAS_PUSH: begin
                if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_tp_nxt  = r_tp + 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_set_ovf = 1'b1;
                    // When full, tp+1 aliases the oldest slot, so wrapping overwrites it.
                    if (OVF_WRAP) begin
                        w_wr_en  = 1'b1;
                        w_tp_nxt = r_tp + 1'b1;
                    end
                end
            end
            RAS_POP: begin
                if (!w_empty) begin
                    w_pop_dat_nxt = r_mem[r_tp];
                    w_pop_vld_nxt = 1'b1;
                    w_tp_nxt      = r_tp - 1'b1;
                    w_cnt_nxt     = r_cnt - 1'b1;
                end else begin
                    w_pop_dat_nxt = '0;
                    w_set_udf     = 1'b1;
                end
            end
            RAS_SWAP: begin
                // Return and call in one cycle: hand back the old top, replace it in place.
                // With nothing stacked the new return address bypasses straight out.
                w_pop_vld_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop_dat_nxt = r_mem[r_tp];
                    w_wr_en       = 1'b1;
                    w_wr_idx      = r_tp;
                end else begin
                    w_pop_dat_nxt = w_ret_pc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
            r_tp      <= '0;
            r_cnt     <= '0;
            r_pop_dat <= '0;
            r_pop_vld <= 1'b0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr_en) r_mem[w_wr_idx] <= w_ret_pc;
            r_tp      <= w_tp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pop_dat <= w_pop_dat_nxt;
            r_pop_vld <= w_pop_vld_nxt;
            r_full    <= (w_cnt_nxt == FULL_CNT);
            r_empty   <= (w_cnt_nxt == '0);
            r_ovf     <= r_ovf | w_set_ovf;
            r_udf     <= r_udf | w_set_udf;
        end
    end

    assign o_pop_data  = r_pop_dat;
    assign o_pop_valid = r_pop_vld;
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_ovf       = r_ovf;
    assign o_udf       = r_udf;

endmodule

// File: rtl/reg_file_ras.sv
// ID-stage register file (2 read / 1 write, WB-to-ID forwarding) plus a separate return-address stack.
// Latency: 1 cycle for operand reads and for stack pops; all outputs registered.
// Backpressure: none; writes, reads and stack requests are all accepted every cycle.
// Ports: clk, reset_n (async active-low); bus (reg_file_ras_if.slave) carries all requests and results.
module reg_file_ras
    import rf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter bit OVF_WRAP    = DEF_OVF_WRAP
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_file_ras_if.slave bus
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_rd1, r_rd2;
    logic [DATA_W-1:0] w_rd1, w_rd2;

    // Write-through: a same-cycle WB to the register being read wins over the array.
    always_comb begin
        w_rd1 = r_regs[bus.rs1];
        w_rd2 = r_regs[bus.rs2];
        if (bus.WB_regwrite && (bus.ws == bus.rs1)) w_rd1 = bus.wd;
        if (bus.WB_regwrite && (bus.ws == bus.rs2)) w_rd2 = bus.wd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else begin
            if (bus.WB_regwrite) r_regs[bus.ws] <= bus.wd;
            r_rd1 <= w_rd1;
            r_rd2 <= w_rd2;
        end
    end

    assign bus.ID_rd1 = r_rd1;
    assign bus.ID_rd2 = r_rd2;

    ras_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH),
        .OVF_WRAP    (OVF_WRAP)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (bus.ID_push),
        .i_pop       (bus.ID_pop),
        .i_pc        (bus.stack_pc),
        .o_pop_data  (bus.pop_data),
        .o_pop_valid (bus.pop_valid),
        .o_full      (bus.ras_full),
        .o_empty     (bus.ras_empty),
        .o_ovf       (bus.ras_ovf),
        .o_udf       (bus.ras_udf)
    );

endmodule
